// File: rtl/resp_credit_fifo_bridge.sv
// resp_credit_fifo_bridge
//   Buffers the merged response stream (no back-pressure) into a DEPTH-entry
//   circular FIFO and presents it to the master with valid/ready. A credit
//   counter throttles request issue so every outstanding response is
//   guaranteed a free slot.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   req_issue_i         request accepted on the slave side this cycle
//   req_allow_o         credit available, request side may issue
//   data_r_*_i          merged response (valid pulse, rdata, opc, aux)
//   resp_valid_o/ready  head handshake toward the master
//   resp_rdata/opc/aux  head word
//   overflow_o          sticky: response dropped because FIFO was full
//   underflow_o         sticky: response arrived with nothing outstanding
module resp_credit_fifo_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int AUX_WIDTH  = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_issue_i,
  output logic                  req_allow_o,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
  input  logic                  data_r_opc_i,
  input  logic [AUX_WIDTH-1:0]  data_r_aux_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_opc_o,
  output logic [AUX_WIDTH-1:0]  resp_aux_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PTR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORD_WIDTH = 1 + AUX_WIDTH + DATA_WIDTH;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  out_cnt;
  logic [CNT_WIDTH:0]    credit_sum;
  logic                  full;
  logic                  pop;
  logic                  push_ok;
  logic                  issue_ok;
  logic [WORD_WIDTH-1:0] head_word;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
    if (p == PTR_WIDTH'(DEPTH - 1)) next_ptr = '0;
    else                            next_ptr = p + PTR_WIDTH'(1);
  endfunction

  // Credit uses registered state only: a pop or response frees credit
  // one cycle later, never in the same cycle.
  assign credit_sum  = {1'b0, count} + {1'b0, out_cnt};
  assign req_allow_o = credit_sum < (CNT_WIDTH + 1)'(DEPTH);

  assign full         = (count == CNT_WIDTH'(DEPTH));
  assign resp_valid_o = (count != '0);
  assign pop          = resp_valid_o && resp_ready_i;
  // A push into a full FIFO is still accepted if the head leaves this cycle.
  assign push_ok      = data_r_valid_i && (!full || pop);
  // Issues without credit are a protocol violation and are ignored.
  assign issue_ok     = req_issue_i && req_allow_o;

  assign head_word = mem[rd_ptr];
  assign {resp_opc_o, resp_aux_o, resp_rdata_o} = head_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= {data_r_opc_i, data_r_aux_i, data_r_rdata_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop)     rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (issue_ok && !data_r_valid_i) begin
      out_cnt <= out_cnt + CNT_WIDTH'(1);
    end else if (!issue_ok && data_r_valid_i && (out_cnt != '0)) begin
      out_cnt <= out_cnt - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (data_r_valid_i && full && !pop)                  overflow_o  <= 1'b1;
      if (data_r_valid_i && (out_cnt == '0) && !issue_ok)  underflow_o <= 1'b1;
    end
  end

endmodule

// File: doc/resp_credit_fifo_bridge.md
# resp_credit_fifo_bridge

Response-side buffer placed directly downstream of the bridge response tree. It captures the single merged response stream, which has no back-pressure, into a DEPTH-entry FIFO. It then presents the responses to the master port with a valid/ready handshake. A credit counter gates request issue on the request side, so every response that can come back always has a free FIFO slot.

## Interface
- DATA_WIDTH, 32, response read-data width.
- AUX_WIDTH, 8, auxiliary/ID field width.
- DEPTH, 4, FIFO entries and maximum in-flight transactions; legal range 1..16.
- CNT_WIDTH, $clog2(DEPTH+1), width of occupancy and outstanding counters (derived; not to be overridden).

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_issue_i  in  1  one request accepted by the slave side this cycle.
- req_allow_o  out  1  credit available; request side may issue this cycle.
- data_r_valid_i  in  1  merged response valid from response tree (one-cycle pulse per response).
- data_r_rdata_i  in  DATA_WIDTH  merged read data.
- data_r_opc_i  in  1  merged response opcode/error bit.
- data_r_aux_i  in  AUX_WIDTH  merged aux field.
- resp_valid_o  out  1  FIFO head valid.
- resp_ready_i  in  1  master accepts head.
- resp_rdata_o  out  DATA_WIDTH  head read data.
- resp_opc_o  out  1  head opcode.
- resp_aux_o  out  AUX_WIDTH  head aux.
- overflow_o  out  1  sticky: response arrived with FIFO full and no pop.
- underflow_o  out  1  sticky: response arrived with zero outstanding.

## Operation
- State: circular FIFO (wr_ptr, rd_ptr, count), outstanding counter `out_cnt`, two sticky error flags.
- push = data_r_valid_i; pop = resp_valid_o && resp_ready_i.
- Storage word = {opc, aux, rdata}; written at wr_ptr on push. Pointers wrap DEPTH-1 -> 0; DEPTH need not be a power of two.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- out_cnt: +1 on req_issue_i only, -1 on data_r_valid_i only, unchanged on both or neither. Saturates at 0 on underflow. Does not increment when req_issue_i arrives while req_allow_o=0 (protocol violation; ignored).
- req_allow_o = (count + out_cnt) < DEPTH. Combinational from registered state only; no same-cycle pop or response credit-forwarding.
- resp_valid_o = (count != 0). Head outputs = storage[rd_ptr]. Head holds stable while valid && !ready.
- Push when count==DEPTH and no pop: word dropped, pointers/count unchanged, overflow_o set.
- Push when count==DEPTH with pop in the same cycle: accepted, count stays DEPTH.
- data_r_valid_i with out_cnt==0 and no same-cycle req_issue_i: underflow_o set. Data is still pushed subject to the full rule.
- Sticky flags clear only on reset.

## Timing
- Reset (async, rst_n=0): pointers, count, out_cnt = 0; storage = 0; resp_valid_o=0; resp_* data = 0; req_allow_o=1; overflow_o=underflow_o=0.
- Response latency: response at data_r_valid_i in cycle N appears on resp_valid_o in cycle N+1 when the FIFO was empty. There is no fall-through.
- Credit latency: a pop or response in cycle N raises req_allow_o in cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained. With count=DEPTH/2 and steady traffic, req_allow_o stays 1.
- Reset mid-operation: all in-flight state is discarded immediately. Responses arriving afterwards set underflow_o.

## Test plan
- Reset, DEPTH=4: outputs as reset values; req_allow_o=1 -> after 4 req_issue_i pulses with no responses, req_allow_o=0 in the cycle after the 4th.
- Issue 2 requests, inject rdata 0xA5A5_0001/aux 0x11 then 0xA5A5_0002/aux 0x22, resp_ready_i=1 -> resp_valid_o one cycle after each, order preserved, req_allow_o returns 1.
- Fill 4 responses with resp_ready_i=0 -> count=4, req_allow_o=0, head stays 0x…0001. Then ready=1 for 4 cycles -> drains in order, resp_valid_o=0 afterwards.
- Full FIFO, fifth data_r_valid_i with ready=0 -> overflow_o=1 and the dropped word never appears. Repeat with ready=1 the same cycle -> accepted, no overflow.
- data_r_valid_i with no prior issue -> underflow_o=1 next cycle, out_cnt stays 0, response delivered.
- Assert rst_n=0 with 3 entries queued -> resp_valid_o=0 immediately (async), req_allow_o=1, flags 0.
